// File: rtl/enc_uart_tx.sv
// Encrypting, ECC-protected UART transmitter: valid/ready FIFO front end,
// XOR key, check-bit matrix, optional even parity, LSB-first serialiser.
module enc_uart_tx #(
  parameter int unsigned K            = 8,
  parameter int unsigned CHK_W        = 4,
  parameter logic [((CHK_W > 0) ? CHK_W : 1)*K-1:0] CHK_MASK = 32'hDBED8EF0,
  parameter logic [K-1:0] KEY         = '1,
  parameter int unsigned PAR_EN       = 1,
  parameter int unsigned STOP_BITS    = 1,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned DEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [K-1:0]             in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     tx_en,
  output logic                     txd,
  output logic                     busy,
  output logic                     tx_done,
  output logic [$clog2(DEPTH):0]   fifo_count
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = (CHK_W > 0) ? CHK_W : 1;
  localparam int unsigned PW  = K + CHK_W + 1;
  localparam int unsigned BCW = 5;
  localparam int unsigned BDW = $clog2(CLKS_PER_BIT + 1);

  typedef enum logic [2:0] {IDLE, START, DATA, CHECK, PARITY, STOP} state_t;

  localparam state_t AFTER_CHK  = (PAR_EN != 0) ? PARITY : STOP;
  localparam state_t AFTER_DATA = (CHK_W > 0) ? CHECK : AFTER_CHK;

  state_t           state, state_nxt;
  logic [K-1:0]     mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic [BDW-1:0]   baud_cnt, baud_nxt;
  logic [BCW-1:0]   bit_cnt, bit_nxt;
  logic [PW-1:0]    sh, sh_nxt, payload;
  logic [K-1:0]     enc;
  logic [CW-1:0]    chk;
  logic             par;
  logic             txd_nxt, busy_nxt, done_nxt;
  logic             push, pop, can_start, bit_tick, stop_end;

  assign in_ready   = (count != (AW+1)'(DEPTH));
  assign fifo_count = count;
  assign push       = in_valid && in_ready;
  assign can_start  = tx_en && (count != '0);
  assign bit_tick   = (baud_cnt == BDW'(CLKS_PER_BIT - 1));
  assign stop_end   = (state == STOP) && bit_tick && (bit_cnt == BCW'(STOP_BITS - 1));
  assign pop        = can_start && ((state == IDLE) || stop_end);

  // Encode the FIFO head: key, check bits, parity, packed in wire order.
  always_comb begin
    enc = mem[rd_ptr] ^ KEY;
    chk = '0;
    for (int j = 0; j < int'(CHK_W); j++) chk[j] = ^(enc & CHK_MASK[j*K +: K]);
    par = (PAR_EN != 0) ? (^enc ^ ^chk) : 1'b0;
    payload = '0;
    payload[K-1:0] = enc;
    for (int j = 0; j < int'(CHK_W); j++) payload[K+j] = chk[j];
    payload[PW-1] = par;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (can_start) state_nxt = START;
      START:   if (bit_tick) state_nxt = DATA;
      DATA:    if (bit_tick && (bit_cnt == BCW'(K - 1))) state_nxt = AFTER_DATA;
      CHECK:   if (bit_tick && (bit_cnt == BCW'(CHK_W - 1))) state_nxt = AFTER_CHK;
      PARITY:  if (bit_tick) state_nxt = STOP;
      STOP:    if (stop_end) state_nxt = can_start ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of counters, shifter and the registered outputs.
  always_comb begin
    baud_nxt = baud_cnt;
    bit_nxt  = bit_cnt;
    sh_nxt   = sh;
    txd_nxt  = 1'b1;
    if ((state == IDLE) || bit_tick) baud_nxt = '0;
    else                             baud_nxt = baud_cnt + BDW'(1);
    if (state_nxt != state) bit_nxt = '0;
    else if (bit_tick)      bit_nxt = bit_cnt + BCW'(1);
    if (pop) sh_nxt = payload;
    else if (bit_tick && ((state == DATA) || (state == CHECK) || (state == PARITY)))
      sh_nxt = sh >> 1;
    case (state_nxt)
      START:                txd_nxt = 1'b0;
      DATA, CHECK, PARITY:  txd_nxt = sh_nxt[0];
      default:              txd_nxt = 1'b1;
    endcase
    busy_nxt = (state_nxt != IDLE);
    done_nxt = (state_nxt == STOP) && (bit_nxt == BCW'(STOP_BITS - 1)) &&
               (baud_nxt == BDW'(CLKS_PER_BIT - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      baud_cnt <= '0;
      bit_cnt  <= '0;
      sh       <= '0;
      txd      <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      baud_cnt <= baud_nxt;
      bit_cnt  <= bit_nxt;
      sh       <= sh_nxt;
      txd      <= txd_nxt;
      busy     <= busy_nxt;
      tx_done  <= done_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + (AW+1)'(1);
      else if (pop && !push) count <= count - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

endmodule

// File: tb/tb_enc_uart_tx.sv
// Directed bench for enc_uart_tx: default build, no-ECC two-stop build,
// and a one-clock-per-bit build.
module tb_enc_uart_tx;

  logic       clk;
  logic       rst_n;
  logic [7:0] d0, d1, d2;
  logic       v0, v1, v2, r0, r1, r2, en0, en1, en2;
  logic       txd0, txd1, txd2, busy0, busy1, busy2, done0, done1, done2;
  logic [2:0] cnt0, cnt1, cnt2;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  enc_uart_tx u0 (
    .clk(clk), .rst_n(rst_n), .in_data(d0), .in_valid(v0), .in_ready(r0),
    .tx_en(en0), .txd(txd0), .busy(busy0), .tx_done(done0), .fifo_count(cnt0));

  enc_uart_tx #(.CHK_W(0), .CHK_MASK(8'h00), .KEY(8'h00), .PAR_EN(0), .STOP_BITS(2)) u1 (
    .clk(clk), .rst_n(rst_n), .in_data(d1), .in_valid(v1), .in_ready(r1),
    .tx_en(en1), .txd(txd1), .busy(busy1), .tx_done(done1), .fifo_count(cnt1));

  enc_uart_tx #(.CLKS_PER_BIT(1)) u2 (
    .clk(clk), .rst_n(rst_n), .in_data(d2), .in_valid(v2), .in_ready(r2),
    .tx_en(en2), .txd(txd2), .busy(busy2), .tx_done(done2), .fifo_count(cnt2));

  typedef struct {
    logic [7:0] data;
    logic [7:0] e;
    logic [3:0] c;
    logic       p;
  } vec_t;

  vec_t        tbl [7];
  logic [7:0]  c_dat [4];
  logic [15:0] c_frm [4];
  int          n_tests = 0;
  int          n_fail  = 0;
  int          bk, bguard, fk, fguard, saw_full;
  logic        bacc, facc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] frame15(input vec_t v);
    return {1'b0, 1'b1, v.p, v.c, v.e, 1'b0};
  endfunction

  function automatic logic get_txd(input int w);
    case (w)
      0:       return txd0;
      1:       return txd1;
      default: return txd2;
    endcase
  endfunction

  function automatic logic get_done(input int w);
    case (w)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic get_busy(input int w);
    case (w)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  task automatic set_in(input int w, input logic [7:0] d, input logic v);
    case (w)
      0:       begin d0 = d; v0 = v; end
      1:       begin d1 = d; v1 = v; end
      default: begin d2 = d; v2 = v; end
    endcase
  endtask

  // One-cycle handshake issued from a falling edge.
  task automatic push(input int w, input logic [7:0] d);
    set_in(w, d, 1'b1);
    @(negedge clk);
    set_in(w, d, 1'b0);
  endtask

  // Waits up to max_wait cycles for the start bit, then checks every cycle of the frame.
  task automatic frame_check(input int w, input logic [15:0] exp, input int nbits,
                             input int cpb, input int max_wait, input string name);
    int waited = 0;
    @(negedge clk);
    while (get_txd(w) !== 1'b0 && waited < max_wait) begin
      @(negedge clk);
      waited++;
    end
    chk({name, " start"}, 32'(get_txd(w)), 32'd0);
    if (get_txd(w) !== 1'b0) return;
    for (int i = 0; i < nbits*cpb; i++) begin
      if (i > 0) @(negedge clk);
      chk($sformatf("%s txd cyc%0d", name, i), 32'(get_txd(w)), 32'(exp[i/cpb]));
      chk($sformatf("%s tx_done cyc%0d", name, i), 32'(get_done(w)), 32'(i == nbits*cpb-1));
      chk($sformatf("%s busy cyc%0d", name, i), 32'(get_busy(w)), 32'd1);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{8'h35, 8'hCA, 4'h6, 1'b0};
    tbl[1] = '{8'h00, 8'hFF, 4'h0, 1'b0};
    tbl[2] = '{8'hFF, 8'h00, 4'h0, 1'b0};
    tbl[3] = '{8'hFE, 8'h01, 4'hC, 1'b1};
    tbl[4] = '{8'h7F, 8'h80, 4'hF, 1'b1};
    tbl[5] = '{8'h5A, 8'hA5, 4'h0, 1'b0};
    tbl[6] = '{8'h12, 8'hED, 4'h3, 1'b0};
    c_dat[0] = 8'hA5; c_frm[0] = 16'h074A;
    c_dat[1] = 8'h00; c_frm[1] = 16'h0600;
    c_dat[2] = 8'hFF; c_frm[2] = 16'h07FE;
    c_dat[3] = 8'h3C; c_frm[3] = 16'h0678;

    rst_n = 1'b0;
    d0 = '0; d1 = '0; d2 = '0;
    v0 = 1'b0; v1 = 1'b0; v2 = 1'b0;
    en0 = 1'b1; en1 = 1'b1; en2 = 1'b1;
    saw_full = 0;
    repeat (2) @(negedge clk);
    chk("rst txd", 32'(txd0), 32'd1);
    chk("rst busy", 32'(busy0), 32'd0);
    chk("rst tx_done", 32'(done0), 32'd0);
    chk("rst in_ready", 32'(r0), 32'd1);
    chk("rst fifo_count", 32'(cnt0), 32'd0);
    chk("rst txd u1", 32'(txd1), 32'd1);
    chk("rst txd u2", 32'(txd2), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post-rst txd", 32'(txd0), 32'd1);
    chk("post-rst busy", 32'(busy0), 32'd0);

    // Single frames from idle, table driven.
    for (int k = 0; k < 7; k++) begin
      push(0, tbl[k].data);
      chk($sformatf("A%0d count after push", k), 32'(cnt0), 32'd1);
      chk($sformatf("A%0d txd before pop", k), 32'(txd0), 32'd1);
      frame_check(0, frame15(tbl[k]), 15, 4, 0, $sformatf("A%0d", k));
      @(negedge clk);
      chk($sformatf("A%0d idle busy", k), 32'(busy0), 32'd0);
      chk($sformatf("A%0d idle txd", k), 32'(txd0), 32'd1);
      chk($sformatf("A%0d idle count", k), 32'(cnt0), 32'd0);
    end

    // Continuous in_valid: FIFO fills, frames run back-to-back in order.
    fork
      begin
        bk = 0; bguard = 0;
        while (bk < 7 && bguard < 3000) begin
          d0 = tbl[bk].data; v0 = 1'b1;
          if (cnt0 == 3'd4) begin
            saw_full++;
            chk("B in_ready when full", 32'(r0), 32'd0);
          end
          bacc = r0;
          @(negedge clk);
          bguard++;
          if (bacc) bk++;
        end
        v0 = 1'b0;
        chk("B words accepted", 32'(bk), 32'd7);
      end
      begin
        for (int k = 0; k < 7; k++)
          frame_check(0, frame15(tbl[k]), 15, 4, (k == 0) ? 4 : 0, $sformatf("B%0d", k));
      end
    join
    chk("B fifo reached full", 32'(saw_full > 0), 32'd1);
    @(negedge clk);
    chk("B idle count", 32'(cnt0), 32'd0);

    // No ECC, no parity, two stop bits, zero key.
    for (int k = 0; k < 4; k++) begin
      push(1, c_dat[k]);
      chk($sformatf("C%0d count", k), 32'(cnt1), 32'd1);
      frame_check(1, c_frm[k], 11, 4, 0, $sformatf("C%0d", k));
      @(negedge clk);
      chk($sformatf("C%0d idle busy", k), 32'(busy1), 32'd0);
      chk($sformatf("C%0d idle txd", k), 32'(txd1), 32'd1);
    end

    // tx_en gating, including drop mid-frame.
    en0 = 1'b0;
    push(0, tbl[0].data);
    push(0, tbl[3].data);
    repeat (3) @(negedge clk);
    chk("D held count", 32'(cnt0), 32'd2);
    chk("D held txd", 32'(txd0), 32'd1);
    chk("D held busy", 32'(busy0), 32'd0);
    en0 = 1'b1;
    fork
      frame_check(0, frame15(tbl[0]), 15, 4, 0, "D0");
      begin
        repeat (8) @(negedge clk);
        en0 = 1'b0;
      end
    join
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk($sformatf("D gated txd cyc%0d", i), 32'(txd0), 32'd1);
      chk($sformatf("D gated busy cyc%0d", i), 32'(busy0), 32'd0);
    end
    chk("D gated count", 32'(cnt0), 32'd1);
    en0 = 1'b1;
    frame_check(0, frame15(tbl[3]), 15, 4, 0, "D1");
    @(negedge clk);
    chk("D final count", 32'(cnt0), 32'd0);

    // One clock per bit: simultaneous push/pop, then pointer wrap over 10 words.
    en2 = 1'b0;
    push(2, tbl[0].data);
    push(2, tbl[1].data);
    chk("F preload count", 32'(cnt2), 32'd2);
    fork
      begin
        d2 = tbl[2].data; v2 = 1'b1; en2 = 1'b1;
        @(negedge clk);
        chk("F push+pop count", 32'(cnt2), 32'd2);
        fk = 3; fguard = 0;
        while (fk < 10 && fguard < 1000) begin
          d2 = tbl[fk % 7].data; v2 = 1'b1;
          facc = r2;
          @(negedge clk);
          fguard++;
          if (facc) fk++;
        end
        v2 = 1'b0;
        chk("F words accepted", 32'(fk), 32'd10);
      end
      begin
        for (int k = 0; k < 10; k++)
          frame_check(2, frame15(tbl[k % 7]), 15, 1, 0, $sformatf("F%0d", k));
      end
    join
    @(negedge clk);
    chk("F idle count", 32'(cnt2), 32'd0);
    chk("F idle busy", 32'(busy2), 32'd0);

    // Reset during DATA bit 3 with words still queued.
    push(0, tbl[0].data);
    push(0, tbl[1].data);
    push(0, tbl[2].data);
    repeat (16) @(negedge clk);
    chk("E pre-rst busy", 32'(busy0), 32'd1);
    chk("E pre-rst txd data bit3", 32'(txd0), 32'd1);
    chk("E pre-rst count", 32'(cnt0), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("E rst txd", 32'(txd0), 32'd1);
    chk("E rst busy", 32'(busy0), 32'd0);
    chk("E rst count", 32'(cnt0), 32'd0);
    chk("E rst in_ready", 32'(r0), 32'd1);
    chk("E rst tx_done", 32'(done0), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk($sformatf("E after rst txd cyc%0d", i), 32'(txd0), 32'd1);
      chk($sformatf("E after rst tx_done cyc%0d", i), 32'(done0), 32'd0);
    end
    chk("E after rst busy", 32'(busy0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
